mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one external synchronous memory port between the instruction-fetch requester (read-only) and the MEM-stage load/store requester.
//  Sits between pc/if_id and mem on one side and the memory bus on the other.
//  Raises per-requester stall requests for the pipeline ctrl block.
//  MEM has fixed priority over IF because it is the older instruction.
// PARAMETERS
//  ADDR_W          32   address width
//  DATA_W          32   data width; SEL_W = DATA_W/8
//  TIMEOUT_CYCLES  255  watchdog limit in cycles awaiting bus_ack (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk           in   1       single clock, all state on rising edge
//  rst           in   1       synchronous, active-high reset
//  flush         in   1       pipeline flush; cancels the IF access
//  if_req        in   1       IF read request, level-held until if_ack
//  if_addr       in   ADDR_W  fetch address
//  if_rdata      out  DATA_W  fetched word, valid with if_ack
//  if_ack        out  1       one-cycle completion pulse
//  mem_req       in   1       MEM request, level-held until mem_ack
//  mem_we        in   1       1 = store, 0 = load
//  mem_sel       in   SEL_W   byte enables
//  mem_addr      in   ADDR_W  data address
//  mem_wdata     in   DATA_W  store data
//  mem_rdata     out  DATA_W  load data, valid with mem_ack
//  mem_ack       out  1       one-cycle completion pulse
//  bus_req       out  1       bus strobe, held until bus_ack
//  bus_we / bus_sel / bus_addr / bus_wdata  out   registered, stable while bus_req=1
//  bus_rdata     in   DATA_W  read data, valid with bus_ack
//  bus_ack       in   1       slave completion, one cycle
//  stallreq_if   out  1       if_req & ~if_ack (combinational)
//  stallreq_mem  out  1       mem_req & ~mem_ack (combinational)
//  bus_err       out  1       one-cycle timeout pulse (ARB_TIMEOUT_EN only)
// BEHAVIOUR
//  Reset: state=IDLE; all registered outputs 0, including bus_*, acks, rdata and bus_err.
//    Applies mid-transaction too; the outstanding bus cycle is abandoned.
//  States and transitions:
//  - IDLE -> MEM_BUSY if mem_req & ~mem_ack; else -> IF_BUSY if if_req & ~if_ack & ~flush.
//    Latch bus_* from the granted requester at that edge.
//    A requester whose ack is high this cycle is ignored, so it is not re-granted.
//  - MEM_BUSY: hold bus_req. On bus_ack -> IDLE, mem_ack=1, mem_rdata=bus_rdata (rdata registered for loads and stores).
//  - IF_BUSY: on bus_ack -> IDLE, if_ack=1, if_rdata=bus_rdata.
//    On flush without bus_ack -> IF_DROP.
//    flush and bus_ack in the same cycle -> IDLE with no if_ack.
//  - IF_DROP: hold bus_req until bus_ack, discard data, -> IDLE. No if_ack.
//  Latency and throughput:
//  - Minimum latency with a zero-wait slave: req at cycle 0, bus_req at 1, bus_ack at 1, ack at 2.
//  - Back-to-back: at most one idle bus cycle between transactions.
//  - Bus transfer is never preempted: a mem_req arriving during IF_BUSY waits for IDLE.
//  Simultaneous requests: MEM wins; IF stays stalled and is granted the next IDLE cycle.
//  Bus address is word-aligned as supplied; the arbiter does not check alignment.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//  - A counter runs in every BUSY/DROP state.
//  - When the count reaches TIMEOUT_CYCLES without bus_ack: bus_req=0 -> IDLE, bus_err pulses.
//  - The owning requester (if not dropped) gets ack with rdata=0.
//  ARB_TIMEOUT_EN undefined: no counter; bus_err tied 0; waits forever.
// STRUCTURE
//  defines.v: state encodings (ArbIdle, ArbIfBusy, ArbMemBusy, ArbIfDrop), RstEnable, widths.
//  One sub-module, arb_watchdog: counter with start, clear and expire signals. Instantiated only under ARB_TIMEOUT_EN.
// TESTING
//  1. Zero-wait slave, if_req addr 0x0000_0040, rdata 0x2401_0005 -> bus_req at cycle 1; if_ack=1 and if_rdata=0x2401_0005 at cycle 2.
//  2. if_req and mem_req (store 0xDEAD_BEEF to 0x100, sel 4'b1111) in the same cycle -> bus_we=1 first, mem_ack; then IF granted; stallreq_if high throughout.
//  3. IF in flight, slave waits 3 cycles, flush at wait cycle 1 -> bus_req held until bus_ack, no if_ack, then IDLE.
//  4. rst asserted during MEM_BUSY -> next edge bus_req=0, mem_ack=0, state IDLE; new if_req is serviced normally.
//  5. mem_req held through its ack cycle, then dropped -> exactly one bus transaction.
//  6. ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks -> at cycle 5 of the wait: bus_err=1, mem_ack=1, mem_rdata=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the mem_arbiter block: FSM state encoding, reset
// polarity and the byte-select width helper.
package mem_arbiter_pkg;

  // Level of rst_i that resets the block.
  localparam logic RstEnable = 1'b1;

  // Bus ownership states of the arbiter.
  typedef enum logic [1:0] {
    ArbIdle    = 2'd0,
    ArbIfBusy  = 2'd1,
    ArbMemBusy = 2'd2,
    ArbIfDrop  = 2'd3
  } arb_state_t;

  // Number of byte enables for a data word.
  function automatic int sel_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Bus watchdog for mem_arbiter: counts the cycles a bus transfer has been
// outstanding and flags expiry after LIMIT cycles without completion.
// Only instantiated when ARB_TIMEOUT_EN is defined.
module mem_arbiter_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int  LIMIT = 255,
  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,   // transfer granted this cycle
  input  logic clear_i,   // transfer finishes this cycle (ack or expiry)
  output logic expire_o   // LIMIT-th outstanding cycle without completion
);

  logic             run_q;
  logic [CNT_W-1:0] cnt_q;

  // Count outstanding cycles from the grant edge until the transfer ends.
  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= '0;
    end else if (clear_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (run_q) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = run_q && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory bus between the instruction
// fetch port (read-only) and the MEM-stage load/store port. MEM has fixed
// priority; a granted transfer is never preempted. A flush cancels the
// fetch: an in-flight fetch is drained from the bus without an ack.
// Optional feature: define ARB_TIMEOUT_EN to abort transfers that wait
// TIMEOUT_CYCLES without bus_ack (bus_err pulse, owner acked with rdata 0).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int  ADDR_W         = 32,
  parameter int  DATA_W         = 32,
  parameter int  TIMEOUT_CYCLES = 255,
  localparam int SEL_W          = sel_width(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  // instruction fetch port
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  // load/store port
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [SEL_W-1:0]  mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  // memory bus
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [SEL_W-1:0]  bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  // pipeline control
  output logic              stallreq_if_o,
  output logic              stallreq_mem_o,
  output logic              bus_err_o
);

  arb_state_t        state_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [SEL_W-1:0]  bus_sel_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic              if_ack_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              mem_ack_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              bus_err_q;

  // A requester whose ack is showing this cycle is finished, even if it
  // still holds its request line; it must not be granted again.
  logic mem_go;
  logic if_go;
  logic expire;

  assign mem_go = mem_req_i & ~mem_ack_q;
  assign if_go  = if_req_i & ~if_ack_q & ~flush_i;

`ifdef ARB_TIMEOUT_EN
  logic wd_start;
  logic wd_clear;

  assign wd_start = (state_q == ArbIdle) & (mem_go | if_go);
  assign wd_clear = (state_q != ArbIdle) & (bus_ack_i | expire);

  mem_arbiter_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (wd_start),
    .clear_i  (wd_clear),
    .expire_o (expire)
  );
`else
  // Without the watchdog a transfer waits for bus_ack indefinitely.
  assign expire = 1'b0;
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Arbitration FSM with registered bus strobes, acks and read data.
  // NOTE: every register here uses <= so all of them update together from
  // the values present before the edge; mixing in = would create order races.
  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable) begin
      state_q     <= ArbIdle;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      mem_ack_q   <= 1'b0;
      mem_rdata_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      bus_err_q <= 1'b0;
      case (state_q)
        ArbIdle: begin
          if (mem_go) begin
            state_q     <= ArbMemBusy;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_we_i;
            bus_sel_q   <= mem_sel_i;
            bus_addr_q  <= mem_addr_i;
            bus_wdata_q <= mem_wdata_i;
          end else if (if_go) begin
            state_q     <= ArbIfBusy;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '1;
            bus_addr_q  <= if_addr_i;
            bus_wdata_q <= '0;
          end
        end
        ArbMemBusy: begin
          if (bus_ack_i) begin
            state_q     <= ArbIdle;
            bus_req_q   <= 1'b0;
            mem_ack_q   <= 1'b1;
            mem_rdata_q <= bus_rdata_i;
          end else if (expire) begin
            state_q     <= ArbIdle;
            bus_req_q   <= 1'b0;
            mem_ack_q   <= 1'b1;
            mem_rdata_q <= '0;
            bus_err_q   <= 1'b1;
          end
        end
        ArbIfBusy: begin
          if (bus_ack_i || expire) begin
            state_q   <= ArbIdle;
            bus_req_q <= 1'b0;
            bus_err_q <= ~bus_ack_i;
            // a flush in the completing cycle still discards the word
            if (!flush_i) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus_ack_i ? bus_rdata_i : '0;
            end
          end else if (flush_i) begin
            state_q <= ArbIfDrop;
          end
        end
        ArbIfDrop: begin
          if (bus_ack_i || expire) begin
            state_q   <= ArbIdle;
            bus_req_q <= 1'b0;
            bus_err_q <= ~bus_ack_i;
          end
        end
        default: begin
          state_q   <= ArbIdle;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req_o      = bus_req_q;
  assign bus_we_o       = bus_we_q;
  assign bus_sel_o      = bus_sel_q;
  assign bus_addr_o     = bus_addr_q;
  assign bus_wdata_o    = bus_wdata_q;
  assign if_ack_o       = if_ack_q;
  assign if_rdata_o     = if_rdata_q;
  assign mem_ack_o      = mem_ack_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign bus_err_o      = bus_err_q;
  assign stallreq_if_o  = if_req_i & ~if_ack_q;
  assign stallreq_mem_o = mem_req_i & ~mem_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized
// traffic from both requesters against a wait-state bus slave. Expected
// read data comes from a word-level memory model; a monitor pops the
// expectation queues on every ack.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata_o;
  logic          if_ack_o;
  logic          mem_req;
  logic          mem_we;
  logic [SW-1:0] mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata_o;
  logic          mem_ack_o;
  logic          bus_req_o;
  logic          bus_we_o;
  logic [SW-1:0] bus_sel_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ack = 1'b0;
  logic          stallreq_if_o;
  logic          stallreq_mem_o;
  logic          bus_err_o;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .if_req_i       (if_req),
    .if_addr_i      (if_addr),
    .if_rdata_o     (if_rdata_o),
    .if_ack_o       (if_ack_o),
    .mem_req_i      (mem_req),
    .mem_we_i       (mem_we),
    .mem_sel_i      (mem_sel),
    .mem_addr_i     (mem_addr),
    .mem_wdata_i    (mem_wdata),
    .mem_rdata_o    (mem_rdata_o),
    .mem_ack_o      (mem_ack_o),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_sel_o      (bus_sel_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_rdata_i    (bus_rdata),
    .bus_ack_i      (bus_ack),
    .stallreq_if_o  (stallreq_if_o),
    .stallreq_mem_o (stallreq_mem_o),
    .bus_err_o      (bus_err_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference memory model ----------------
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    if (slv_mem.exists(a)) return slv_mem[a];
    return init_word(a);
  endfunction

  // ---------------- bus slave ----------------
  int slv_wait_mode = -1;   // -1: random wait states, else fixed count
  bit slv_mute      = 1'b0; // never acknowledge
  bit slv_busy      = 1'b0;
  int slv_left      = 0;
  int slv_acks      = 0;

  always @(posedge clk) begin
    #1;
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    if (bus_req_o !== 1'b1) begin
      slv_busy = 1'b0;
    end else begin
      if (!slv_busy) begin
        slv_busy = 1'b1;
        if (slv_wait_mode >= 0) slv_left = slv_wait_mode;
        else slv_left = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(3, 1));
      end
      if (!slv_mute) begin
        if (slv_left == 0) begin
          bus_ack   = 1'b1;
          bus_rdata = slv_rd(bus_addr_o);
          if (bus_we_o) slv_mem[bus_addr_o] = merge(slv_rd(bus_addr_o), bus_wdata_o, bus_sel_o);
          slv_acks++;
          slv_busy  = 1'b0;
        end else begin
          slv_left--;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [31:0] if_exp_q[$];
  logic [31:0] mem_exp_q[$];
  bit          err_allowed = 1'b0;
  logic        pr_req = 1'b0;
  logic        pr_ack = 1'b0;
  logic [5:0]  pr_ctl = '0;
  logic [63:0] pr_dat = '0;

  always @(negedge clk) begin
    if (rst) begin
      pr_req = 1'b0;
      pr_ack = 1'b0;
    end else begin
      if (if_ack_o === 1'b1) begin
        if (if_exp_q.size() == 0) check("if_ack unexpected", if_ack_o, 1'b0);
        else check("if_rdata", if_rdata_o, if_exp_q.pop_front());
      end
      if (mem_ack_o === 1'b1) begin
        if (mem_exp_q.size() == 0) check("mem_ack unexpected", mem_ack_o, 1'b0);
        else check("mem_rdata", mem_rdata_o, mem_exp_q.pop_front());
      end
      check("stallreq_if", stallreq_if_o, if_req & ~if_ack_o);
      check("stallreq_mem", stallreq_mem_o, mem_req & ~mem_ack_o);
      if (!err_allowed) begin
        check("bus_err quiet", bus_err_o, 1'b0);
        if (pr_req && !pr_ack) begin
          check("bus ctl stable", {bus_req_o, bus_we_o, bus_sel_o}, pr_ctl);
          check("bus addr/wdata stable", {bus_addr_o, bus_wdata_o}, pr_dat);
        end
      end
      if (pr_req && pr_ack) check("bus_req released after ack", bus_req_o, 1'b0);
      pr_req = bus_req_o;
      pr_ack = bus_ack;
      pr_ctl = {bus_req_o, bus_we_o, bus_sel_o};
      pr_dat = {bus_addr_o, bus_wdata_o};
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_if(input logic [31:0] a);
    if_req  = 1'b1;
    if_addr = a;
    if_exp_q.push_back(ref_rd(a));
  endtask

  task automatic issue_mem(input logic we, input logic [31:0] a, input logic [3:0] sel,
                           input logic [31:0] d);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = a;
    mem_sel   = sel;
    mem_wdata = d;
    mem_exp_q.push_back(ref_rd(a));
    if (we) ref_mem[a] = merge(ref_rd(a), d, sel);
  endtask

  task automatic wait_ack(input bit is_mem, input int bound);
    int n = 0;
    while (((is_mem ? mem_ack_o : if_ack_o) !== 1'b1) && n < bound) begin
      tick();
      n++;
    end
    if (is_mem) check("mem ack within bound", mem_ack_o, 1'b1);
    else check("if ack within bound", if_ack_o, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global time limit: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  bit if_pend = 1'b0, if_lin = 1'b0, if_drop = 1'b0;
  bit mem_pend = 1'b0, mem_lin = 1'b0;

  initial begin
    int n0;
    int n;
    rst = 1'b1; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    tick();
    tick();
    check("reset bus_req", bus_req_o, 1'b0);
    check("reset bus ctl", {bus_we_o, bus_sel_o}, 5'h0);
    check("reset bus addr/wdata", {bus_addr_o, bus_wdata_o}, 64'h0);
    check("reset acks/err", {if_ack_o, mem_ack_o, bus_err_o}, 3'b000);
    check("reset rdata", {if_rdata_o, mem_rdata_o}, 64'h0);
    rst = 1'b0;

    // 1: zero-wait fetch latency
    slv_wait_mode = 0;
    slv_mem[32'h40] = 32'h2401_0005;
    ref_mem[32'h40] = 32'h2401_0005;
    tick();
    issue_if(32'h0000_0040);
    tick();
    check("t1 bus_req at cycle 1", bus_req_o, 1'b1);
    check("t1 bus_addr", bus_addr_o, 32'h40);
    tick();
    check("t1 if_ack at cycle 2", if_ack_o, 1'b1);
    check("t1 if_rdata", if_rdata_o, 32'h2401_0005);
    if_req = 1'b0;

    // 2: simultaneous requests, MEM store first
    tick();
    issue_mem(1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF);
    issue_if(32'h44);
    tick();
    check("t2 store granted first", {bus_req_o, bus_we_o, bus_sel_o}, 6'b11_1111);
    check("t2 store addr/wdata", {bus_addr_o, bus_wdata_o}, {32'h100, 32'hDEAD_BEEF});
    check("t2 stallreq_if c1", stallreq_if_o, 1'b1);
    tick();
    check("t2 mem_ack", mem_ack_o, 1'b1);
    check("t2 stallreq_if c2", stallreq_if_o, 1'b1);
    mem_req = 1'b0;
    tick();
    check("t2 fetch granted next", {bus_req_o, bus_we_o}, 2'b10);
    check("t2 fetch addr", bus_addr_o, 32'h44);
    check("t2 stallreq_if c3", stallreq_if_o, 1'b1);
    tick();
    check("t2 if_ack", if_ack_o, 1'b1);
    if_req = 1'b0;

    // 3: flush while a fetch waits on a slow slave
    tick();
    slv_wait_mode = 3;
    issue_if(32'h48);
    tick();
    check("t3 bus_req wait1", bus_req_o, 1'b1);
    flush = 1'b1;
    void'(if_exp_q.pop_back());
    tick();
    flush = 1'b0;
    if_req = 1'b0;
    check("t3 bus_req held wait2", bus_req_o, 1'b1);
    tick();
    check("t3 bus_req held wait3", bus_req_o, 1'b1);
    tick();
    check("t3 bus_req held until ack", bus_req_o, 1'b1);
    tick();
    check("t3 back to idle", {bus_req_o, if_ack_o}, 2'b00);
    tick();
    check("t3 no late if_ack", if_ack_o, 1'b0);

    // 4: reset during MEM_BUSY, then a fetch is serviced normally
    slv_wait_mode = 6;
    issue_mem(1'b0, 32'h104, 4'hF, 32'h0);
    tick();
    check("t4 bus_req before reset", bus_req_o, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    check("t4 reset drops bus_req", bus_req_o, 1'b0);
    check("t4 reset mem_ack/rdata", {mem_ack_o, mem_rdata_o}, 33'h0);
    rst = 1'b0;
    mem_req = 1'b0;
    mem_exp_q.delete();
    slv_wait_mode = -1;
    issue_if(32'h4C);
    wait_ack(1'b0, 20);
    if_req = 1'b0;

    // 5: request held through its ack cycle is served exactly once
    tick();
    n0 = slv_acks;
    issue_mem(1'b0, 32'h108, 4'hF, 32'h0);
    wait_ack(1'b1, 20);
    check("t5 stallreq_mem in ack cycle", stallreq_mem_o, 1'b0);
    tick();
    mem_req = 1'b0;
    repeat (4) tick();
    check("t5 single bus transaction", 64'(slv_acks - n0), 64'd1);

`ifdef ARB_TIMEOUT_EN
    // 6: slave never answers; watchdog aborts after TO cycles
    tick();
    slv_mute    = 1'b1;
    err_allowed = 1'b1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h10C; mem_sel = 4'hF; mem_wdata = '0;
    mem_exp_q.push_back(32'h0);
    for (int c = 1; c <= TO; c++) begin
      tick();
      check("t6 waiting", {bus_req_o, bus_err_o, mem_ack_o}, 3'b100);
    end
    tick();
    check("t6 timeout outputs", {bus_req_o, bus_err_o, mem_ack_o}, 3'b011);
    check("t6 mem_rdata zero", mem_rdata_o, 32'h0);
    mem_req = 1'b0;
    tick();
    check("t6 bus_err one pulse", bus_err_o, 1'b0);
    slv_mute    = 1'b0;
    err_allowed = 1'b0;
`endif

    // random traffic
    slv_wait_mode = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      flush = 1'b0;
      if (if_ack_o === 1'b1) begin
        if_pend = 1'b0;
        if ($urandom_range(1, 0) == 1) if_lin = 1'b1;
        else if_req = 1'b0;
      end else if (if_lin || if_drop) begin
        if_req  = 1'b0;
        if_lin  = 1'b0;
        if_drop = 1'b0;
      end else if (if_pend && $urandom_range(15, 0) == 0) begin
        flush = 1'b1;
        void'(if_exp_q.pop_back());
        if_pend = 1'b0;
        if_drop = 1'b1;
      end else if (!if_pend && $urandom_range(2, 0) == 0) begin
        issue_if(32'($urandom_range(63, 0)) * 32'd4);
        if_pend = 1'b1;
      end else if (!if_pend && $urandom_range(31, 0) == 0) begin
        flush = 1'b1;
      end

      if (mem_ack_o === 1'b1) begin
        mem_pend = 1'b0;
        if ($urandom_range(1, 0) == 1) mem_lin = 1'b1;
        else mem_req = 1'b0;
      end else if (mem_lin) begin
        mem_req = 1'b0;
        mem_lin = 1'b0;
      end else if (!mem_pend && $urandom_range(2, 0) == 0) begin
        issue_mem(1'($urandom_range(1, 0)), 32'h100 + 32'($urandom_range(15, 0)) * 32'd4,
                  4'($urandom_range(15, 1)), $urandom);
        mem_pend = 1'b1;
      end
    end

    // drain outstanding requests
    n = 0;
    while ((if_pend || mem_pend) && n < 100) begin
      tick();
      flush = 1'b0;
      if (if_ack_o === 1'b1) if_pend = 1'b0;
      if (!if_pend) if_req = 1'b0;
      if (mem_ack_o === 1'b1) mem_pend = 1'b0;
      if (!mem_pend) mem_req = 1'b0;
      n++;
    end
    check("drain completes", {if_pend, mem_pend}, 2'b00);
    if_req  = 1'b0;
    mem_req = 1'b0;
    tick();
    tick();
    check("if scoreboard empty", 64'(if_exp_q.size()), 64'd0);
    check("mem scoreboard empty", 64'(mem_exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
